// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus: instruction-memory port, decoder issue handshake and branch resolution.
interface instruction_fetch_if;
    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [ILEN-1:0] imem_data;
    logic [ILEN-1:0] instruction;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] issue_pc;
    logic            branch_resolve;
    logic            branch;
    logic            unconditional_branch;
    logic            zero;
    logic [XLEN-1:0] branch_offset;
    logic [ILEN-1:0] fetch_count;

    modport master (
        output imem_req, imem_addr, instruction, instr_valid, issue_pc, fetch_count,
        input  imem_ack, imem_data, instr_ready, branch_resolve, branch,
               unconditional_branch, zero, branch_offset
    );

    modport slave (
        input  imem_req, imem_addr, instruction, instr_valid, issue_pc, fetch_count,
        output imem_ack, imem_data, instr_ready, branch_resolve, branch,
               unconditional_branch, zero, branch_offset
    );
endinterface

// File: rtl/instruction_fetch.sv
// Single-issue fetch unit: FETCH -> ISSUE -> RESOLVE loop, one instruction in flight.
// FETCH_COUNT_INIT only exists to let a bench start fetch_count near its wrap point.
module instruction_fetch #(
    parameter logic [63:0] RESET_PC         = 64'h0,
    parameter logic [31:0] FETCH_COUNT_INIT = 32'h0
) (
    input logic                 clock_i,
    input logic                 reset_n_i,
    instruction_fetch_if.master bus
);
    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        ISSUE   = 2'd1,
        RESOLVE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] issue_pc_q, issue_pc_d;
    logic [ILEN-1:0] instr_q, instr_d;
    logic [ILEN-1:0] count_q, count_d;
    logic            req_q, req_d;
    logic            valid_q, valid_d;
    logic            taken_c;
    logic [XLEN-1:0] step_c;

    // Branch step: word offset scaled to bytes when taken, else next sequential word.
    always_comb begin
        taken_c = bus.unconditional_branch | (bus.branch & bus.zero);
        step_c  = taken_c ? (bus.branch_offset << 2) : XLEN'(4);
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            issue_pc_q <= '0;
            instr_q    <= '0;
            count_q    <= FETCH_COUNT_INIT;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            issue_pc_q <= issue_pc_d;
            instr_q    <= instr_d;
            count_q    <= count_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
        end
    end

    // Ack is only honoured once the request is visible, so the post-reset idle cycle ignores it.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        issue_pc_d = issue_pc_q;
        instr_d    = instr_q;
        count_d    = count_q;
        unique case (state_q)
            FETCH: begin
                if (req_q && bus.imem_ack) begin
                    instr_d    = bus.imem_data;
                    issue_pc_d = pc_q;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.instr_ready) begin
                    count_d = count_q + ILEN'(1);
                    state_d = RESOLVE;
                end
            end
            RESOLVE: begin
                if (bus.branch_resolve) begin
                    pc_d    = issue_pc_q + step_c;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
        req_d   = (state_d == FETCH);
        valid_d = (state_d == ISSUE);
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instruction = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.issue_pc    = issue_pc_q;
    assign bus.fetch_count = count_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboarded bench for instruction_fetch: driver pushes expected fetches/issues, monitor pops and compares.
module tb_instruction_fetch;
    localparam logic [63:0] RESET_PC = 64'h0;

    typedef struct packed {
        logic [31:0] data;
        logic [63:0] pc;
        logic [31:0] cnt;
    } issue_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic [63:0] exp_addr_q[$];
    issue_t      exp_issue_q[$];
    logic [63:0] m_pc;
    logic [31:0] m_cnt;

    instruction_fetch_if bus ();
    instruction_fetch_if bus2 ();

    instruction_fetch #(.RESET_PC(RESET_PC)) dut (
        .clock_i  (clk),
        .reset_n_i(rst_n),
        .bus      (bus.master)
    );

    instruction_fetch #(.RESET_PC(RESET_PC), .FETCH_COUNT_INIT(32'hFFFF_FFFE)) dut2 (
        .clock_i  (clk),
        .reset_n_i(rst_n),
        .bus      (bus2.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the main DUT: new request / new issue pops the scoreboard, held ones must stay put.
    logic   prev_req = 1'b0;
    logic   prev_valid = 1'b0;
    logic [63:0] cur_addr = '0;
    issue_t cur_iss = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req   = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (bus.imem_req && !prev_req) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_fetch actual=%h required=none", bus.imem_addr);
                end else begin
                    cur_addr = exp_addr_q.pop_front();
                    check("fetch_addr", bus.imem_addr, cur_addr);
                end
            end else if (bus.imem_req) begin
                check("fetch_addr_hold", bus.imem_addr, cur_addr);
            end
            if (bus.instr_valid && !prev_valid) begin
                if (exp_issue_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue actual=%h required=none", bus.instruction);
                end else begin
                    cur_iss = exp_issue_q.pop_front();
                    check("issue_instr", 64'(bus.instruction), 64'(cur_iss.data));
                    check("issue_pc", bus.issue_pc, cur_iss.pc);
                    check("issue_count", 64'(bus.fetch_count), 64'(cur_iss.cnt));
                end
            end else if (bus.instr_valid) begin
                check("issue_instr_hold", 64'(bus.instruction), 64'(cur_iss.data));
                check("issue_pc_hold", bus.issue_pc, cur_iss.pc);
                check("issue_count_hold", 64'(bus.fetch_count), 64'(cur_iss.cnt));
            end
            if (bus.instr_valid && bus.imem_req)
                check("req_valid_exclusive", 64'(1), 64'(0));
            prev_req   = bus.imem_req;
            prev_valid = bus.instr_valid;
        end
    end

    // Free-running second DUT starting its counter two below the wrap point.
    logic [31:0] exp2 = 32'hFFFF_FFFE;
    logic        saw_max2 = 1'b0;
    logic        saw_wrap2 = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp2 = 32'hFFFF_FFFE;
        end else begin
            check("wrap_count", 64'(bus2.fetch_count), 64'(exp2));
            if (bus2.fetch_count == 32'hFFFF_FFFF) saw_max2 = 1'b1;
            if (saw_max2 && bus2.fetch_count == 32'h0) saw_wrap2 = 1'b1;
            if (bus2.instr_valid) exp2 = exp2 + 32'd1;
        end
    end

    initial begin
        bus2.imem_ack             = 1'b1;
        bus2.imem_data            = 32'h1234_5678;
        bus2.instr_ready          = 1'b1;
        bus2.branch_resolve       = 1'b1;
        bus2.branch               = 1'b0;
        bus2.unconditional_branch = 1'b0;
        bus2.zero                 = 1'b0;
        bus2.branch_offset        = '0;
    end

    task automatic wait_for_req();
        int n = 0;
        bus.imem_ack = 1'b0;
        while (!bus.imem_req && n < 50) begin
            tick();
            n++;
        end
        if (!bus.imem_req) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout actual=0 required=1");
        end
    endtask

    task automatic wait_for_valid();
        int n = 0;
        while (!bus.instr_valid && n < 50) begin
            tick();
            n++;
        end
        if (!bus.instr_valid) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout actual=0 required=1");
        end
    endtask

    task automatic expect_fetch(input logic [63:0] t);
        wait_for_req();
        check("fetch_target", bus.imem_addr, t);
    endtask

    // One complete fetch/issue/resolve loop with optional stalls and stray events.
    task automatic do_loop(input logic [31:0] data, input int ack_stall, input int rdy_stall,
                           input int res_delay, input logic br, input logic ub, input logic zr,
                           input logic [63:0] off, input logic stray, input logic concurrent);
        issue_t e;
        wait_for_req();
        for (int i = 0; i < ack_stall; i++) begin
            bus.imem_data            = $urandom;
            bus.branch_resolve       = stray && (i == 0);
            bus.unconditional_branch = 1'b1;
            bus.branch_offset        = 64'h40;
            tick();
        end
        bus.branch_resolve = 1'b0;
        bus.imem_ack       = 1'b1;
        bus.imem_data      = data;
        e.data = data;
        e.pc   = m_pc;
        e.cnt  = m_cnt;
        exp_issue_q.push_back(e);
        tick();
        bus.imem_ack = 1'b0;
        wait_for_valid();
        for (int i = 0; i < rdy_stall; i++) begin
            bus.imem_ack       = 1'($urandom);
            bus.imem_data      = $urandom;
            bus.branch_resolve = stray && (i == 0);
            tick();
        end
        bus.imem_ack             = 1'b0;
        bus.branch_resolve       = concurrent;
        bus.unconditional_branch = 1'b1;
        bus.branch_offset        = 64'h80;
        bus.instr_ready          = 1'b1;
        tick();
        m_cnt = m_cnt + 32'd1;
        bus.instr_ready    = 1'b0;
        bus.branch_resolve = 1'b0;
        for (int i = 0; i < res_delay; i++) begin
            bus.imem_ack = 1'($urandom);
            tick();
        end
        bus.branch_resolve       = 1'b1;
        bus.branch               = br;
        bus.unconditional_branch = ub;
        bus.zero                 = zr;
        bus.branch_offset        = off;
        if (ub || (br && zr)) m_pc = m_pc + off * 64'd4;
        else                  m_pc = m_pc + 64'd4;
        exp_addr_q.push_back(m_pc);
        tick();
        bus.branch_resolve       = 1'b0;
        bus.imem_ack             = 1'b0;
        bus.branch               = 1'($urandom);
        bus.unconditional_branch = 1'($urandom);
        bus.zero                 = 1'($urandom);
        bus.branch_offset        = {$urandom, $urandom};
    endtask

    task automatic jump_to(input logic [63:0] t);
        do_loop($urandom, 0, 0, 0, 1'b0, 1'b1, 1'b0, (t - m_pc) >> 2, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0;
        int          o;
        logic [63:0] off;

        rst_n                    = 1'b0;
        bus.imem_ack             = 1'b0;
        bus.imem_data            = '0;
        bus.instr_ready          = 1'b0;
        bus.branch_resolve       = 1'b0;
        bus.branch               = 1'b0;
        bus.unconditional_branch = 1'b0;
        bus.zero                 = 1'b0;
        bus.branch_offset        = '0;
        m_pc  = RESET_PC;
        m_cnt = 32'd0;
        repeat (3) tick();

        check("rst_req", 64'(bus.imem_req), 64'(0));
        check("rst_valid", 64'(bus.instr_valid), 64'(0));
        check("rst_addr", bus.imem_addr, RESET_PC);
        check("rst_instr", 64'(bus.instruction), 64'(0));
        check("rst_issue_pc", bus.issue_pc, 64'(0));
        check("rst_count", 64'(bus.fetch_count), 64'(0));

        exp_addr_q.push_back(RESET_PC);
        rst_n = 1'b1;
        tick();
        check("req_after_release", 64'(bus.imem_req), 64'(1));

        // Sequential loops, fixed word, no stalls.
        for (int i = 0; i < 3; i++) begin
            c0 = cyc;
            do_loop(32'h8B02_0020, 0, 0, 0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
            expect_fetch(64'(4 * (i + 1)));
            check("loop_latency", 64'(cyc - c0), 64'(3));
        end

        jump_to(64'h100);
        do_loop($urandom, 0, 0, 0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        expect_fetch(64'hF8);

        jump_to(64'h40);
        do_loop($urandom, 0, 0, 0, 1'b1, 1'b0, 1'b0, 64'd5, 1'b0, 1'b0);
        expect_fetch(64'h44);
        do_loop($urandom, 0, 0, 0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        expect_fetch(64'h40);
        do_loop($urandom, 0, 0, 0, 1'b1, 1'b0, 1'b1, 64'd5, 1'b0, 1'b0);
        expect_fetch(64'h54);

        // Long stalls with stray resolves in FETCH/ISSUE and one coincident with the handshake.
        do_loop(32'hCAFE_F00D, 7, 5, 2, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1);
        expect_fetch(64'h58);

        jump_to(64'hFFFF_FFFF_FFFF_FFFC);
        do_loop($urandom, 0, 0, 1, 1'b1, 1'b0, 1'b0, 64'd9, 1'b0, 1'b0);
        expect_fetch(64'h0);

        // Reset in the middle of an unaccepted issue, with coincident ack and resolve.
        wait_for_req();
        bus.imem_ack  = 1'b1;
        bus.imem_data = 32'hDEAD_BEEF;
        exp_issue_q.push_back('{data: 32'hDEAD_BEEF, pc: m_pc, cnt: m_cnt});
        tick();
        bus.imem_ack = 1'b0;
        wait_for_valid();
        tick();
        rst_n                    = 1'b0;
        bus.imem_ack             = 1'b1;
        bus.branch_resolve       = 1'b1;
        bus.unconditional_branch = 1'b1;
        tick();
        check("midrst_valid", 64'(bus.instr_valid), 64'(0));
        check("midrst_req", 64'(bus.imem_req), 64'(0));
        check("midrst_count", 64'(bus.fetch_count), 64'(0));
        check("midrst_instr", 64'(bus.instruction), 64'(0));
        check("midrst_issue_pc", bus.issue_pc, 64'(0));
        bus.imem_ack       = 1'b0;
        bus.branch_resolve = 1'b0;
        tick();
        m_pc  = RESET_PC;
        m_cnt = 32'd0;
        exp_addr_q.push_back(RESET_PC);
        rst_n = 1'b1;
        tick();
        expect_fetch(RESET_PC);

        // Randomized loops against the scoreboard model.
        for (int k = 0; k < 40; k++) begin
            o = int'($urandom_range(0, 40)) - 20;
            if ($urandom_range(0, 7) == 0) off = {$urandom, $urandom};
            else                           off = 64'(o);
            do_loop($urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 3) == 0),
                    1'($urandom), off, 1'($urandom), ($urandom_range(0, 3) == 0));
        end

        repeat (3) tick();
        check("addr_queue_drained", 64'(exp_addr_q.size()), 64'(0));
        check("issue_queue_drained", 64'(exp_issue_q.size()), 64'(0));
        check("final_count", 64'(bus.fetch_count), 64'(m_cnt));
        check("count_wrapped", 64'(saw_wrap2), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
